// File: rtl/sipo_shift_reg_pkg.sv
// +----------------------------------------------------------------------+
// | sipo_shift_reg_pkg : shared state encoding for the SIPO assembler     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package sipo_shift_reg_pkg;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

endpackage

`default_nettype wire

// File: rtl/sipo_shift_reg_dff_rst.sv
// +----------------------------------------------------------------------+
// | dff_rst : 1-bit D flip-flop, sync active-low reset, load enable       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module dff_rst (
   input  logic En,
   input  logic Rst_n,
   input  logic Ld,
   input  logic D,
   output logic Q
);

   logic r_q;

   always_ff @(posedge En) begin
      if (!Rst_n) begin
         r_q <= 1'b0;
      end else if (Ld) begin
         r_q <= D;
      end
   end

   assign Q = r_q;

endmodule

`default_nettype wire

// File: rtl/sipo_shift_reg.sv
// +----------------------------------------------------------------------+
// | sipo_shift_reg : framed serial-in / parallel-out word assembler       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module sipo_shift_reg
   import sipo_shift_reg_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             En,
   input  logic             Rst_n,
   input  logic             Din,
   input  logic             Din_valid,
   input  logic             Sof,
   output logic [WIDTH-1:0] Dout,
   output logic             Dout_valid,
   output logic             Frame_err,
   output logic             Busy
);

   localparam int             c_cw   = $clog2(WIDTH);
   localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);
   localparam logic [c_cw-1:0] c_one  = c_cw'(1);

   state_t            r_state;
   state_t            w_state_next;
   logic [c_cw-1:0]   r_count;
   logic [c_cw-1:0]   w_count_next;
   logic [WIDTH-1:0]  r_sr;
   logic [WIDTH-1:0]  w_sr_next;
   logic [WIDTH-1:0]  w_sr_shifted;
   logic [WIDTH-1:0]  w_sr_loaded;
   logic              w_sr_ld;
   logic [WIDTH-1:0]  r_dout;
   logic              r_dout_valid;
   logic              w_dout_valid_next;
   logic              r_frame_err;
   logic              w_frame_err_next;

   // A fresh word clears the register so stale bits never leak into Dout.
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign w_sr_shifted = {r_sr[WIDTH-2:0], Din};
         assign w_sr_loaded  = {{(WIDTH-1){1'b0}}, Din};
      end else begin : g_lsb_first
         assign w_sr_shifted = {Din, r_sr[WIDTH-1:1]};
         assign w_sr_loaded  = {Din, {(WIDTH-1){1'b0}}};
      end
   endgenerate

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         dff_rst u_bit (
            .En    (En),
            .Rst_n (Rst_n),
            .Ld    (w_sr_ld),
            .D     (w_sr_next[i]),
            .Q     (r_sr[i])
         );
      end
   endgenerate

   always_comb begin
      w_state_next      = r_state;
      w_count_next      = r_count;
      w_sr_next         = r_sr;
      w_sr_ld           = 1'b0;
      w_dout_valid_next = 1'b0;
      w_frame_err_next  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (Din_valid && Sof) begin
               w_sr_ld      = 1'b1;
               w_sr_next    = w_sr_loaded;
               w_count_next = c_one;
               w_state_next = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (Din_valid) begin
               w_sr_ld = 1'b1;
               if (Sof) begin
                  w_sr_next        = w_sr_loaded;
                  w_count_next     = c_one;
                  w_frame_err_next = 1'b1;
               end else begin
                  w_sr_next = w_sr_shifted;
                  if (r_count == c_last) begin
                     w_count_next      = '0;
                     w_state_next      = S_IDLE;
                     w_dout_valid_next = 1'b1;
                  end else begin
                     w_count_next = r_count + c_one;
                  end
               end
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge En) begin
      if (!Rst_n) begin
         r_state      <= S_IDLE;
         r_count      <= '0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_count      <= w_count_next;
         r_dout_valid <= w_dout_valid_next;
         r_frame_err  <= w_frame_err_next;
         if (w_dout_valid_next) begin
            r_dout <= w_sr_next;
         end
      end
   end

   assign Dout       = r_dout;
   assign Dout_valid = r_dout_valid;
   assign Frame_err  = r_frame_err;
   assign Busy       = (r_state == S_SHIFT);

endmodule

`default_nettype wire

// File: tb/tb_sipo_shift_reg.sv
// +----------------------------------------------------------------------+
// | tb_sipo_shift_reg : bench for both bit orders of sipo_shift_reg       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_sipo_shift_reg;

   localparam int W = 8;

   logic         En = 1'b0;
   logic         Rst_n;
   logic         Din;
   logic         Din_valid;
   logic         Sof;
   logic [W-1:0] dout1, dout0;
   logic         dv1, dv0, fe1, fe0, busy1, busy0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 En = ~En;

   sipo_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .En(En), .Rst_n(Rst_n), .Din(Din), .Din_valid(Din_valid), .Sof(Sof),
      .Dout(dout1), .Dout_valid(dv1), .Frame_err(fe1), .Busy(busy1)
   );

   sipo_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .En(En), .Rst_n(Rst_n), .Din(Din), .Din_valid(Din_valid), .Sof(Sof),
      .Dout(dout0), .Dout_valid(dv0), .Frame_err(fe0), .Busy(busy0)
   );

   // Reference: the word in progress is just the list of bits received since Sof.
   bit           q[$];
   logic [W-1:0] m_dout1 = '0;
   logic [W-1:0] m_dout0 = '0;
   logic         m_dv    = 1'b0;
   logic         m_fe    = 1'b0;

   task automatic model_update(input logic rn, input logic dv, input logic sf, input logic d);
      m_dv = 1'b0;
      m_fe = 1'b0;
      if (!rn) begin
         q.delete();
         m_dout1 = '0;
         m_dout0 = '0;
      end else if (dv) begin
         if (sf) begin
            m_fe = (q.size() != 0);
            q.delete();
            q.push_back(d);
         end else if (q.size() != 0) begin
            q.push_back(d);
            if (q.size() == W) begin
               for (int k = 0; k < W; k++) begin
                  m_dout1[W-1-k] = q[k];
                  m_dout0[k]     = q[k];
               end
               m_dv = 1'b1;
               q.delete();
            end
         end
      end
   endtask

   function automatic void chk8(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic void chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endfunction

   task automatic cyc(input logic rn, input logic dv, input logic sf, input logic d, input string tag);
      Rst_n     = rn;
      Din_valid = dv;
      Sof       = sf;
      Din       = d;
      @(posedge En);
      model_update(rn, dv, sf, d);
      #1;
      chk8({tag, " dout msb"}, dout1, m_dout1);
      chk8({tag, " dout lsb"}, dout0, m_dout0);
      chk1({tag, " dv msb"}, dv1, m_dv);
      chk1({tag, " dv lsb"}, dv0, m_dv);
      chk1({tag, " fe msb"}, fe1, m_fe);
      chk1({tag, " fe lsb"}, fe0, m_fe);
      chk1({tag, " busy msb"}, busy1, q.size() != 0);
      chk1({tag, " busy lsb"}, busy0, q.size() != 0);
      chk1({tag, " dv/fe excl"}, dv1 & fe1, 1'b0);
   endtask

   typedef struct {
      logic         rn, dv, sof, din;
      logic [W-1:0] e_dout1, e_dout0;
      logic         e_dv, e_fe, e_busy;
   } vec_t;

   vec_t tbl[12];

   initial begin
      tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hB2, 8'h4D, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hB2, 8'h4D, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hB2, 8'h4D, 1'b0, 1'b0, 1'b0};

      // Reset, the reference stream in both bit orders, then a stray bit in IDLE.
      for (int i = 0; i < 12; i++) begin
         cyc(tbl[i].rn, tbl[i].dv, tbl[i].sof, tbl[i].din, $sformatf("vec%0d", i));
         chk8($sformatf("vec%0d tbl dout msb", i), dout1, tbl[i].e_dout1);
         chk8($sformatf("vec%0d tbl dout lsb", i), dout0, tbl[i].e_dout0);
         chk1($sformatf("vec%0d tbl dv", i), dv1, tbl[i].e_dv);
         chk1($sformatf("vec%0d tbl fe", i), fe1, tbl[i].e_fe);
         chk1($sformatf("vec%0d tbl busy", i), busy1, tbl[i].e_busy);
      end

      // Early Sof after three bits.
      cyc(1'b1, 1'b1, 1'b1, 1'b1, "t4 b0");
      cyc(1'b1, 1'b1, 1'b0, 1'b1, "t4 b1");
      cyc(1'b1, 1'b1, 1'b0, 1'b1, "t4 b2");
      cyc(1'b1, 1'b1, 1'b1, 1'b1, "t4 sof");
      chk1("t4 fe at sof msb", fe1, 1'b1);
      chk1("t4 fe at sof lsb", fe0, 1'b1);
      chk1("t4 busy at sof", busy1, 1'b1);
      for (int k = 0; k < 7; k++) begin
         cyc(1'b1, 1'b1, 1'b0, 1'b0, "t4 tail");
         if (k == 0) chk1("t4 fe one cycle", fe1, 1'b0);
      end
      chk8("t4 dout msb", dout1, 8'h80);
      chk8("t4 dout lsb", dout0, 8'h01);
      chk1("t4 dv", dv1, 1'b1);

      // Back-to-back start, then a 5-cycle gap mid-word (Sof ignored while invalid).
      cyc(1'b1, 1'b1, 1'b1, 1'b0, "t5 b0");
      chk1("t5 b2b busy", busy1, 1'b1);
      chk1("t5 b2b no fe", fe1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, "t5 b1");
      cyc(1'b1, 1'b1, 1'b0, 1'b1, "t5 b2");
      for (int k = 0; k < 5; k++) begin
         cyc(1'b1, 1'b0, k[0], ~k[0], "t5 gap");
      end
      chk1("t5 gap busy", busy1, 1'b1);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, "t5 b3");
      cyc(1'b1, 1'b1, 1'b0, 1'b1, "t5 b4");
      cyc(1'b1, 1'b1, 1'b0, 1'b0, "t5 b5");
      cyc(1'b1, 1'b1, 1'b0, 1'b1, "t5 b6");
      cyc(1'b1, 1'b1, 1'b0, 1'b1, "t5 b7");
      chk8("t5 dout msb", dout1, 8'h6B);
      chk8("t5 dout lsb", dout0, 8'hD6);
      chk1("t5 dv", dv1, 1'b1);

      // Reset after bit 4, then a clean all-ones word.
      cyc(1'b1, 1'b1, 1'b1, 1'b1, "t6 b0");
      for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b0, 1'b1, "t6 b");
      cyc(1'b0, 1'b1, 1'b0, 1'b1, "t6 rst");
      chk1("t6 rst busy", busy1, 1'b0);
      chk1("t6 rst no fe", fe1, 1'b0);
      chk8("t6 rst dout", dout1, 8'h00);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, "t6 w0");
      for (int k = 0; k < 7; k++) cyc(1'b1, 1'b1, 1'b0, 1'b1, "t6 w");
      chk8("t6 dout msb", dout1, 8'hFF);
      chk8("t6 dout lsb", dout0, 8'hFF);
      chk1("t6 dv", dv1, 1'b1);

      // Random traffic against the reference.
      for (int n = 0; n < 3000; n++) begin
         cyc($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 11) == 0, 1'($urandom), "rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
